// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: turns a PC fetch request into a single Avalon-style
// read, holds the returned word and reports completion or faults to control.
module instr_fetch_unit #(
  parameter bit          ENDIAN_SWAP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_done,
  output logic        fetch_error,
  output logic [1:0]  error_code,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, READ, ERROR} state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_done_q, fetch_done_d;
  logic        fetch_error_q, fetch_error_d;
  logic [1:0]  error_code_q, error_code_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] timer_q, timer_d;
  logic        flushed_q, flushed_d;
  logic [31:0] rd_word;

  assign rd_word = ENDIAN_SWAP ? {mem_readdata[7:0], mem_readdata[15:8],
                                  mem_readdata[23:16], mem_readdata[31:24]}
                               : mem_readdata;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_done_d  = 1'b0;
    fetch_error_d = fetch_error_q;
    error_code_d  = error_code_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    timer_d       = timer_q;
    flushed_d     = flushed_q;

    if (flush) begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      IDLE, ERROR: begin
        if (fetch_req) begin
          fetch_error_d = 1'b0;
          error_code_d  = ERR_NONE;
          instr_valid_d = 1'b0;
          flushed_d     = 1'b0;
          if (pc[1:0] != 2'b00) begin
            state_d       = ERROR;
            fetch_error_d = 1'b1;
            error_code_d  = ERR_MISALIGN;
          end else begin
            mem_address_d = pc;
            mem_read_d    = 1'b1;
            timer_d       = 32'd0;
            state_d       = READ;
          end
        end
      end

      READ: begin
        // A flush anywhere in the transaction poisons its data, so remember it
        if (flush) begin
          flushed_d = 1'b1;
        end
        if (mem_waitrequest) begin
          timer_d = timer_q + 32'd1;
          if ((TIMEOUT_CYCLES != 0) && ((timer_q + 32'd1) == TIMEOUT_CYCLES)) begin
            mem_read_d    = 1'b0;
            state_d       = ERROR;
            fetch_error_d = 1'b1;
            error_code_d  = ERR_TIMEOUT;
          end
        end else begin
          mem_read_d = 1'b0;
          state_d    = IDLE;
          if (!(flush || flushed_q)) begin
            instr_d       = rd_word;
            instr_valid_d = 1'b1;
            fetch_done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      fetch_done_q  <= 1'b0;
      fetch_error_q <= 1'b0;
      error_code_q  <= ERR_NONE;
      mem_address_q <= 32'd0;
      mem_read_q    <= 1'b0;
      timer_q       <= 32'd0;
      flushed_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_done_q  <= fetch_done_d;
      fetch_error_q <= fetch_error_d;
      error_code_q  <= error_code_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      timer_q       <= timer_d;
      flushed_q     <= flushed_d;
    end
  end

  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign fetch_done     = fetch_done_q;
  assign fetch_error    = fetch_error_q;
  assign error_code     = error_code_q;
  assign busy           = (state_q == READ);
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_byteenable = {4{mem_read_q}};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: expected instructions are queued
// when a fetch is launched and popped when the DUT signals fetch_done.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_done;
  logic        fetch_error;
  logic [1:0]  error_code;
  logic        busy;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_instr;
  logic [31:0] exp_word;
  int          read_starts = 0;
  logic        mem_read_prev = 1'b0;

  instr_fetch_unit #(
    .ENDIAN_SWAP(1'b1),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .pc(pc),
    .flush(flush),
    .instr(instr),
    .instr_valid(instr_valid),
    .fetch_done(fetch_done),
    .fetch_error(fetch_error),
    .error_code(error_code),
    .busy(busy),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Count bus reads by their rising edge
  always @(posedge clk) begin
    #1;
    if (mem_read && !mem_read_prev) read_starts++;
    mem_read_prev = mem_read;
  end

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Pop the scoreboard when a completion is expected this cycle
  task automatic expect_done(input string name);
    n_checks++;
    if (fetch_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got %b expected 1", name, fetch_done);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard got fetch_done expected empty queue", name);
    end else begin
      exp_word = exp_q.pop_front();
      n_checks++;
      if (instr !== exp_word) begin
        n_fail++;
        $display("FAIL %s_instr got %h expected %h", name, instr, exp_word);
      end
      last_instr = exp_word;
    end
    n_checks++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_valid got %b expected 1", name, instr_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; pc = 32'd0; flush = 1'b0;
    mem_waitrequest = 1'b0; mem_readdata = 32'd0;
    step(); step();
    n_checks++;
    if ({instr, instr_valid, fetch_done, fetch_error, error_code, busy} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%b%b%b%b%b expected all zero",
               instr, instr_valid, fetch_done, fetch_error, error_code, busy);
    end
    n_checks++;
    if ({mem_address, mem_read, mem_byteenable} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_bus got %h %b %h expected 0 0 0", mem_address, mem_read, mem_byteenable);
    end
    reset = 1'b0;
    last_instr = 32'd0;
    step();
  endtask

  task automatic test_zero_wait();
    pc = 32'hBFC00000; fetch_req = 1'b1;
    mem_readdata = 32'h0000E824; mem_waitrequest = 1'b0;
    exp_q.push_back(swap32(32'h0000E824));
    step();
    fetch_req = 1'b0;
    n_checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'hBFC00000 || mem_byteenable !== 4'hF || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_bus got rd=%b addr=%h be=%h busy=%b expected 1 bfc00000 f 1",
               mem_read, mem_address, mem_byteenable, busy);
    end
    step();
    expect_done("zw");
    n_checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_release got rd=%b busy=%b expected 0 0", mem_read, busy);
    end
    step();
    n_checks++;
    if (fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_pulse got %b expected 0", fetch_done);
    end
  endtask

  task automatic test_wait_states();
    pc = 32'h00001000; fetch_req = 1'b1;
    mem_readdata = 32'h11223344;
    exp_q.push_back(32'h44332211);
    step();
    fetch_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (mem_read !== 1'b1 || mem_address !== 32'h00001000 || fetch_done !== 1'b0) begin
        n_fail++;
        $display("FAIL ws_stable_c%0d got rd=%b addr=%h done=%b expected 1 00001000 0",
                 c, mem_read, mem_address, fetch_done);
      end
      mem_waitrequest = (c < 4);
      step();
    end
    expect_done("ws");
    n_checks++;
    if (fetch_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ws_no_timeout got %b expected 0", fetch_error);
    end
    step();
  endtask

  task automatic test_misaligned();
    int starts;
    starts = read_starts;
    pc = 32'hBFC00002; fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    n_checks++;
    if (fetch_error !== 1'b1 || error_code !== 2'b01 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_error got err=%b code=%b busy=%b valid=%b expected 1 01 0 0",
               fetch_error, error_code, busy, instr_valid);
    end
    step(); step();
    n_checks++;
    if (read_starts !== starts || mem_read !== 1'b0 || fetch_error !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_no_read got reads=%0d rd=%b err=%b expected %0d 0 1",
               read_starts, mem_read, fetch_error, starts);
    end
    pc = 32'hBFC00004; fetch_req = 1'b1;
    mem_readdata = 32'h78563412; mem_waitrequest = 1'b0;
    exp_q.push_back(32'h12345678);
    step();
    fetch_req = 1'b0;
    n_checks++;
    if (fetch_error !== 1'b0 || error_code !== 2'b00 || mem_read !== 1'b1 || mem_address !== 32'hBFC00004) begin
      n_fail++;
      $display("FAIL mis_recover got err=%b code=%b rd=%b addr=%h expected 0 00 1 bfc00004",
               fetch_error, error_code, mem_read, mem_address);
    end
    step();
    expect_done("mis");
    step();
  endtask

  task automatic test_timeout();
    pc = 32'h00002000; fetch_req = 1'b1; mem_waitrequest = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (mem_read !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL to_stall_c%0d got rd=%b busy=%b expected 1 1", c, mem_read, busy);
      end
      step();
    end
    n_checks++;
    if (mem_read !== 1'b0 || mem_byteenable !== 4'h0 || busy !== 1'b0 ||
        fetch_error !== 1'b1 || error_code !== 2'b10 || fetch_done !== 1'b0) begin
      n_fail++;
      $display("FAIL to_fault got rd=%b be=%h busy=%b err=%b code=%b done=%b expected 0 0 0 1 10 0",
               mem_read, mem_byteenable, busy, fetch_error, error_code, fetch_done);
    end
    n_checks++;
    if (instr !== last_instr || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_instr got %h/%b expected %h/0", instr, instr_valid, last_instr);
    end
    mem_waitrequest = 1'b0;
    step();
  endtask

  task automatic test_flush_during_read();
    bit seen_done;
    seen_done = 1'b0;
    pc = 32'h00003000; fetch_req = 1'b1; mem_readdata = 32'hAABBCCDD;
    step();
    fetch_req = 1'b0; mem_waitrequest = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; mem_waitrequest = 1'b0;
    n_checks++;
    if (mem_read !== 1'b1 || mem_address !== 32'h00003000) begin
      n_fail++;
      $display("FAIL fl_bus_hold got rd=%b addr=%h expected 1 00003000", mem_read, mem_address);
    end
    step();
    if (fetch_done) seen_done = 1'b1;
    n_checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_complete got rd=%b busy=%b expected 0 0", mem_read, busy);
    end
    step();
    if (fetch_done) seen_done = 1'b1;
    n_checks++;
    if (seen_done || instr !== last_instr || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_discard got done=%b instr=%h valid=%b expected 0 %h 0",
               seen_done, instr, instr_valid, last_instr);
    end
  endtask

  task automatic test_back_to_back();
    // Flush coinciding with a request in IDLE must not cancel it
    pc = 32'h00004400; fetch_req = 1'b1; flush = 1'b1;
    mem_readdata = 32'hDEADBEEF; mem_waitrequest = 1'b0;
    exp_q.push_back(32'hEFBEADDE);
    step();
    flush = 1'b0;
    pc = 32'h00004404;
    step();
    expect_done("b2b_a");
    mem_readdata = 32'h01020304;
    exp_q.push_back(32'h04030201);
    step();
    fetch_req = 1'b0;
    n_checks++;
    if (mem_address !== 32'h00004404 || mem_read !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_addr got %h/%b expected 00004404/1", mem_address, mem_read);
    end
    step();
    expect_done("b2b_b");
    step();
  endtask

  task automatic test_reset_mid_read();
    int starts;
    starts = read_starts;
    pc = 32'h00005000; fetch_req = 1'b1; mem_waitrequest = 1'b1;
    step();
    pc = 32'h00006000;
    step();
    fetch_req = 1'b0;
    n_checks++;
    if (mem_address !== 32'h00005000 || mem_read !== 1'b1 || read_starts !== starts + 1) begin
      n_fail++;
      $display("FAIL rmr_ignore_req got addr=%h rd=%b reads=%0d expected 00005000 1 %0d",
               mem_address, mem_read, read_starts - starts, 1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; mem_waitrequest = 1'b0; mem_readdata = 32'hCAFEF00D;
    n_checks++;
    if ({instr, instr_valid, fetch_done, fetch_error, error_code, busy,
         mem_address, mem_read, mem_byteenable} !== 75'd0) begin
      n_fail++;
      $display("FAIL rmr_reset got instr=%h v=%b d=%b e=%b c=%b b=%b addr=%h rd=%b be=%h expected all zero",
               instr, instr_valid, fetch_done, fetch_error, error_code, busy,
               mem_address, mem_read, mem_byteenable);
    end
    step(); step();
    n_checks++;
    if (fetch_done !== 1'b0 || instr !== 32'd0 || instr_valid !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rmr_late_data got done=%b instr=%h valid=%b rd=%b expected 0 0 0 0",
               fetch_done, instr, instr_valid, mem_read);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_timeout();
    test_flush_during_read();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
